// File: rtl/cdc_hs_bus_tx.sv
// cdc_hs_bus_tx: four-phase req/ack bus transfer from i_src_clk to i_dst_clk.
//
// The source side accepts one word per valid/ready handshake, parks it in a holding register
// and raises a level req. The destination side synchronizes req, copies the held word onto a
// valid/ready stream and acks only after the consumer takes it. The source then drops req and
// waits for ack to fall before it accepts the next word, so every word is delivered exactly
// once and in order, however long the destination stalls.
//
// Ports:
//   i_src_clk    source clock
//   i_dst_clk    destination clock
//   rst_n        asynchronous active-low reset, shared by both domains
//   i_src_data   source word, taken when i_src_valid & o_src_ready
//   i_src_valid  source word valid
//   o_src_ready  source can accept a word (source FSM idle)
//   o_src_busy   a transfer is in flight
//   o_xfer_cnt   completed transfers (source domain), wraps
//   o_dst_data   destination word, stable while o_dst_valid
//   o_dst_valid  destination word valid
//   i_dst_ready  destination consumer accepts the word
module cdc_hs_bus_tx #(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              i_src_clk,
  input  logic              i_dst_clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] i_src_data,
  input  logic              i_src_valid,
  output logic              o_src_ready,
  output logic              o_src_busy,
  output logic [CNT_W-1:0]  o_xfer_cnt,
  output logic [DWIDTH-1:0] o_dst_data,
  output logic              o_dst_valid,
  input  logic              i_dst_ready
);

  if (SYNC_STAGES < 2) begin : gen_bad_sync_stages
    $error("cdc_hs_bus_tx: SYNC_STAGES must be at least 2");
  end

  // ---------------------------------------------------------------------------------------------
  // Source domain
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [1:0] {
    SIdle,
    SReq,
    SAckLo
  } src_state_e;

  src_state_e              src_state_q, src_state_d;
  logic                    req_q, req_d;
  logic [DWIDTH-1:0]       data_q, data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0]  ack_sync_q;
  logic                    ack_s;

  // ---------------------------------------------------------------------------------------------
  // Destination domain
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [1:0] {
    DIdle,
    DHold,
    DAck
  } dst_state_e;

  dst_state_e              dst_state_q, dst_state_d;
  logic                    ack_q, ack_d;
  logic [DWIDTH-1:0]       dst_data_q, dst_data_d;
  logic                    dst_valid_q, dst_valid_d;
  logic [SYNC_STAGES-1:0]  req_sync_q;
  logic                    req_s;

  // ack (dst domain) into the source domain.
  always_ff @(posedge i_src_clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_q};
    end
  end

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // req (src domain) into the destination domain.
  always_ff @(posedge i_dst_clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
    end
  end

  assign req_s = req_sync_q[SYNC_STAGES-1];

  // Source FSM next state. data_q only loads in SIdle, so it is frozen for the whole time the
  // destination may be sampling it (req high until ack seen low again).
  always_comb begin
    src_state_d = src_state_q;
    req_d       = req_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    case (src_state_q)
      SIdle: begin
        if (i_src_valid) begin
          data_d      = i_src_data;
          req_d       = 1'b1;
          src_state_d = SReq;
        end
      end
      SReq: begin
        if (ack_s) begin
          req_d       = 1'b0;
          src_state_d = SAckLo;
        end
      end
      SAckLo: begin
        // The transfer counts as complete only once ack has returned low, so the next req
        // can never be mistaken for the tail of this one.
        if (!ack_s) begin
          cnt_d       = cnt_q + 1'b1;
          src_state_d = SIdle;
        end
      end
      default: begin
        src_state_d = SIdle;
        req_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_src_clk or negedge rst_n) begin
    if (!rst_n) begin
      src_state_q <= SIdle;
      req_q       <= 1'b0;
      data_q      <= '0;
      cnt_q       <= '0;
    end else begin
      src_state_q <= src_state_d;
      req_q       <= req_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_src_ready = (src_state_q == SIdle);
  assign o_src_busy  = ~o_src_ready;
  assign o_xfer_cnt  = cnt_q;

  // Destination FSM next state.
  always_comb begin
    dst_state_d = dst_state_q;
    ack_d       = ack_q;
    dst_data_d  = dst_data_q;
    dst_valid_d = dst_valid_q;
    case (dst_state_q)
      DIdle: begin
        // req_s high means data_q has been stable for at least SYNC_STAGES dst edges.
        if (req_s) begin
          dst_data_d  = data_q;
          dst_valid_d = 1'b1;
          dst_state_d = DHold;
        end
      end
      DHold: begin
        if (i_dst_ready) begin
          dst_valid_d = 1'b0;
          ack_d       = 1'b1;
          dst_state_d = DAck;
        end
      end
      DAck: begin
        // valid stays low here; a fresh word is only presented after req has been seen low.
        if (!req_s) begin
          ack_d       = 1'b0;
          dst_state_d = DIdle;
        end
      end
      default: begin
        dst_state_d = DIdle;
        ack_d       = 1'b0;
        dst_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_dst_clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_state_q <= DIdle;
      ack_q       <= 1'b0;
      dst_data_q  <= '0;
      dst_valid_q <= 1'b0;
    end else begin
      dst_state_q <= dst_state_d;
      ack_q       <= ack_d;
      dst_data_q  <= dst_data_d;
      dst_valid_q <= dst_valid_d;
    end
  end

  assign o_dst_data  = dst_data_q;
  assign o_dst_valid = dst_valid_q;

endmodule

// File: tb/tb_cdc_hs_bus_tx.sv
// tb_cdc_hs_bus_tx: self-checking bench for cdc_hs_bus_tx.
// Words are pushed to a scoreboard queue when the source accepts them and popped when the
// destination handshake happens. A second instance with a 4-bit counter covers the wrap.
`timescale 1ns/1ps
module tb_cdc_hs_bus_tx;

  typedef struct {
    logic [31:0] data;
    int          stall;
    logic [15:0] exp_cnt;
  } vec_t;

  logic        src_clk = 1'b0;
  logic        dst_clk = 1'b0;
  realtime     src_half = 50.0;
  realtime     dst_half = 13.5;
  logic        rst_n;

  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic        src_busy;
  logic [15:0] xfer_cnt;
  logic [31:0] dst_data;
  logic        dst_valid;
  logic        dst_ready = 1'b1;

  logic [31:0] w_data;
  logic        w_valid;
  logic        w_ready;
  logic        w_busy;
  logic [3:0]  w_cnt;
  logic [31:0] w_dst_data;
  logic        w_dst_valid;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] sb[$];
  logic [15:0] model_cnt = '0;
  int          n_deliv = 0;
  bit          pulse_chk = 1'b1;
  int          stall_n = 0;
  int          stall_ctr = 0;
  int          vld_run = 0;

  initial forever #(src_half) src_clk = ~src_clk;
  initial forever #(dst_half) dst_clk = ~dst_clk;

  cdc_hs_bus_tx #(
    .DWIDTH      (32),
    .SYNC_STAGES (2),
    .CNT_W       (16)
  ) dut (
    .i_src_clk   (src_clk),
    .i_dst_clk   (dst_clk),
    .rst_n       (rst_n),
    .i_src_data  (src_data),
    .i_src_valid (src_valid),
    .o_src_ready (src_ready),
    .o_src_busy  (src_busy),
    .o_xfer_cnt  (xfer_cnt),
    .o_dst_data  (dst_data),
    .o_dst_valid (dst_valid),
    .i_dst_ready (dst_ready)
  );

  cdc_hs_bus_tx #(
    .DWIDTH      (32),
    .SYNC_STAGES (2),
    .CNT_W       (4)
  ) dut_w (
    .i_src_clk   (src_clk),
    .i_dst_clk   (dst_clk),
    .rst_n       (rst_n),
    .i_src_data  (w_data),
    .i_src_valid (w_valid),
    .o_src_ready (w_ready),
    .o_src_busy  (w_busy),
    .o_xfer_cnt  (w_cnt),
    .o_dst_data  (w_dst_data),
    .o_dst_valid (w_dst_valid),
    .i_dst_ready (1'b1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: got timeout, want event within bound (t=%0t)", name, $time);
  endtask

  // Destination consumer: holds ready low for stall_n cycles of each valid word.
  initial forever begin
    @(posedge dst_clk);
    #1;
    if (dst_valid) begin
      if (stall_ctr < stall_n) begin
        dst_ready = 1'b0;
        stall_ctr++;
      end else begin
        dst_ready = 1'b1;
      end
    end else begin
      dst_ready = 1'b1;
      stall_ctr = 0;
    end
  end

  // Destination monitor / scoreboard.
  initial forever begin
    @(negedge dst_clk);
    if (!rst_n) begin
      vld_run = 0;
    end else if (dst_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL dst_unexpected: got word 0x%h, want no word (t=%0t)", dst_data, $time);
      end else begin
        check("dst_data", dst_data, sb[0]);
        if (dst_ready) begin
          void'(sb.pop_front());
          n_deliv++;
          if (pulse_chk) check("valid_pulse_width", vld_run + 1, 1);
        end
      end
      if (dst_ready) vld_run = 0;
      else vld_run++;
    end else begin
      vld_run = 0;
    end
  end

  task automatic send_word(input logic [31:0] d);
    int n = 0;
    @(negedge src_clk);
    src_data  = d;
    src_valid = 1'b1;
    while (!src_ready && n < 5000) begin
      @(negedge src_clk);
      n++;
    end
    if (!src_ready) begin
      fail_timeout("src_accept");
      src_valid = 1'b0;
    end else begin
      sb.push_back(d);
      model_cnt++;
      @(posedge src_clk);
    end
  endtask

  task automatic src_idle();
    @(negedge src_clk);
    src_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    do begin
      @(negedge src_clk);
      n++;
    end while (!(sb.size() == 0 && src_ready) && n < 5000);
    if (!(sb.size() == 0 && src_ready)) fail_timeout(name);
  endtask

  task automatic wait_dst_valid(input string name);
    int n = 0;
    while (!dst_valid && n < 2000) begin
      @(negedge dst_clk);
      n++;
    end
    if (!dst_valid) fail_timeout(name);
  endtask

  task automatic w_send(input logic [31:0] d);
    int n = 0;
    @(negedge src_clk);
    w_data  = d;
    w_valid = 1'b1;
    while (!w_ready && n < 5000) begin
      @(negedge src_clk);
      n++;
    end
    if (!w_ready) fail_timeout("wrap_accept");
    else @(posedge src_clk);
    @(negedge src_clk);
    w_valid = 1'b0;
  endtask

  task automatic w_wait_idle();
    int n = 0;
    while (!w_ready && n < 5000) begin
      @(negedge src_clk);
      n++;
    end
    if (!w_ready) fail_timeout("wrap_idle");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, want completion within time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{data: 32'hDEADBEEF, stall: 0, exp_cnt: 16'd1};
    vecs[1] = '{data: 32'h00000000, stall: 0, exp_cnt: 16'd2};
    vecs[2] = '{data: 32'hFFFFFFFF, stall: 3, exp_cnt: 16'd3};
    vecs[3] = '{data: 32'h12345678, stall: 0, exp_cnt: 16'd4};
    vecs[4] = '{data: 32'hA5A55A5A, stall: 7, exp_cnt: 16'd5};
    vecs[5] = '{data: 32'h80000001, stall: 1, exp_cnt: 16'd6};

    rst_n     = 1'b0;
    src_valid = 1'b0;
    src_data  = '0;
    w_valid   = 1'b0;
    w_data    = '0;
    #20;
    check("rst_src_ready", src_ready, 1);
    check("rst_src_busy", src_busy, 0);
    check("rst_xfer_cnt", xfer_cnt, 0);
    check("rst_dst_data", dst_data, 0);
    check("rst_dst_valid", dst_valid, 0);
    check("rst_w_cnt", w_cnt, 0);
    @(negedge src_clk);
    rst_n = 1'b1;

    // Single words, including 0xDEADBEEF with ready held high.
    foreach (vecs[i]) begin
      stall_n   = vecs[i].stall;
      pulse_chk = (vecs[i].stall == 0);
      send_word(vecs[i].data);
      src_idle();
      wait_quiet("vec_done");
      check("vec_xfer_cnt", xfer_cnt, vecs[i].exp_cnt);
      check("vec_src_busy", src_busy, 0);
    end

    // Back-to-back burst, valid held, slow src / fast dst; then fast src / slow dst.
    stall_n   = 0;
    pulse_chk = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        src_half = 6.75;
        dst_half = 50.0;
        repeat (4) @(negedge dst_clk);
      end
      for (int i = 1; i <= 64; i++) send_word(32'(i));
      src_idle();
      wait_quiet("burst_done");
      check("burst_xfer_cnt", xfer_cnt, model_cnt);
    end
    src_half = 50.0;
    dst_half = 13.5;
    repeat (4) @(negedge src_clk);

    // Backpressure: consumer stalls 50 dst cycles.
    stall_n   = 50;
    pulse_chk = 1'b0;
    send_word(32'hC0FFEE00);
    src_idle();
    wait_dst_valid("bp_valid");
    for (int i = 0; i < 45; i++) begin
      @(negedge dst_clk);
      if (i % 5 == 0) begin
        check("bp_dst_valid", dst_valid, 1);
        check("bp_src_ready", src_ready, 0);
      end
    end
    wait_quiet("bp_done");
    check("bp_xfer_cnt", xfer_cnt, model_cnt);

    // Push while busy: the second word waits until the first has completed.
    stall_n = 40;
    send_word(32'h11111111);
    @(negedge src_clk);
    src_data = 32'h22222222;
    for (int i = 0; i < 8; i++) begin
      check("busy_src_ready", src_ready, 0);
      @(negedge src_clk);
    end
    stall_n = 0;
    send_word(32'h22222222);
    #1;
    check("busy_prior_done", xfer_cnt, model_cnt - 16'd1);
    src_idle();
    wait_quiet("busy_done");
    check("busy_xfer_cnt", xfer_cnt, model_cnt);

    // Reset in the middle of a transfer (src in SReq, dst in DHold).
    stall_n = 100000;
    send_word(32'h5EADF00D);
    src_idle();
    wait_dst_valid("rstmid_valid");
    check("rstmid_busy", src_busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rstmid_src_ready", src_ready, 1);
    check("rstmid_src_busy", src_busy, 0);
    check("rstmid_xfer_cnt", xfer_cnt, 0);
    check("rstmid_dst_data", dst_data, 0);
    check("rstmid_dst_valid", dst_valid, 0);
    sb.delete();
    model_cnt = '0;
    stall_n   = 0;
    pulse_chk = 1'b1;
    repeat (3) @(negedge src_clk);
    rst_n = 1'b1;
    begin
      int base;
      base = n_deliv;
      send_word(32'hA5A5A5A5);
      src_idle();
      wait_quiet("rstmid_done");
      check("rstmid_new_cnt", xfer_cnt, 1);
      repeat (20) @(negedge dst_clk);
      check("rstmid_one_delivery", n_deliv - base, 1);
    end

    // Counter wrap on the 4-bit instance: 16 completions -> 0, 17 -> 1.
    for (int i = 1; i <= 17; i++) begin
      w_send(32'(i));
      w_wait_idle();
      if (i == 16) check("wrap_cnt_16", w_cnt, 0);
    end
    check("wrap_cnt_17", w_cnt, 1);
    check("wrap_last_data", w_dst_data, 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
